// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen geometry, coordinate and address
// widths, the write-entry record and the linear address helper.
package fb_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int ADDR_W = 19;

    localparam logic [X_W-1:0] SCREEN_W = 10'd640;
    localparam logic [Y_W-1:0] SCREEN_H = 9'd480;

    // One pending framebuffer write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              color;
    } fb_wr_t;

    // Linear address y*SCREEN_W + x. A 640-wide screen uses two shifts
    // (512 + 128) instead of a multiplier.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] x_ext;
        logic [ADDR_W-1:0] y_ext;
        x_ext = ADDR_W'(x);
        y_ext = ADDR_W'(y);
        if (SCREEN_W == 10'd640)
            return (y_ext << 9) + (y_ext << 7) + x_ext;
        else
            return (y_ext * ADDR_W'(SCREEN_W)) + x_ext;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of framebuffer write entries. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  fb_wr_t wr_data,
    input  logic   pop,
    output fb_wr_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    fb_wr_t         mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

    // Storage write.
    // NOTE: the storage array has no reset; empty/full come only from the
    // pointers, so stale contents are never observed and the array can map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

    // Pointer update; flush discards everything by realigning the pointers.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Pixel stream to framebuffer write port: range check, linear address,
// elastic FIFO and a registered write stage that holds under mem_ready=0.
// Optional macro PIXEL_DEDUP_EN suppresses writes that repeat the last
// issued {addr, color}.
module pixel_write_buffer
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X_W-1:0]    in_x,
    input  logic [Y_W-1:0]    in_y,
    input  logic              in_color,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_data,
    output logic              busy,
    output logic [15:0]       drop_count
);

    logic   full;
    logic   empty;
    logic   in_range;
    logic   accept;
    logic   push;
    logic   pop;
    logic   load;
    logic   dup;
    fb_wr_t wr_in;
    fb_wr_t head;

    assign in_ready = !full;
    assign in_range = (in_x < SCREEN_W) && (in_y < SCREEN_H);
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && in_range;
    assign wr_in    = '{addr: fb_addr(in_x, in_y), color: in_color};

    // The head leaves the FIFO whenever the output stage is free or draining
    // this edge; a duplicate head is dropped instead of loaded.
    assign pop  = !flush && !empty && (!mem_we || mem_ready);
    assign load = pop && !dup;
    assign busy = !empty || mem_we;

    pixel_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .wr_data(wr_in),
        .pop    (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );

    // Output write stage: load from the head, else retire on mem_ready;
    // address and data only change on a load, so they hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= 1'b0;
        end else if (flush) begin
            mem_we <= 1'b0;
        end else if (load) begin
            mem_we   <= 1'b1;
            mem_addr <= head.addr;
            mem_data <= head.color;
        end else if (mem_ready) begin
            mem_we <= 1'b0;
        end
    end

    // Saturating count of accepted out-of-range pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (accept && !in_range && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end

`ifdef PIXEL_DEDUP_EN
    logic   last_valid;
    fb_wr_t last_wr;

    assign dup = last_valid && (head == last_wr);

    // Remember the most recently issued write; flush forgets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid <= 1'b0;
            last_wr    <= '0;
        end else if (flush) begin
            last_valid <= 1'b0;
        end else if (load) begin
            last_valid <= 1'b1;
            last_wr    <= head;
        end
    end
`else
    assign dup = 1'b0;
`endif

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Downstream of the line/clear sequencer: accepts the (x, y, pixel_color) stream the sequencer emits each cycle and turns it into framebuffer write transactions.
- Flow: range check, linear address computation, elastic FIFO, then a registered write port with a stall input. The sequencer can run at full rate while the framebuffer port back-pressures.
- Also reports overflow-free status (busy) and a count of dropped out-of-range pixels.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SCREEN_W, 640, visible width in pixels; drawn from the package.
- SCREEN_H, 480, visible height in pixels; drawn from the package.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of FIFO, output stage and dedup history; drop_count untouched.
- in_valid  in  1  pixel presented.
- in_ready  out  1  buffer can accept; equals !full.
- in_x  in  10  pixel column.
- in_y  in  9  pixel row.
- in_color  in  1  pixel value.
- mem_we  out  1  write request valid.
- mem_ready  in  1  framebuffer accepts the write this cycle.
- mem_addr  out  19  linear address.
- mem_data  out  1  pixel value to write.
- busy  out  1  FIFO non-empty or mem_we high.
- drop_count  out  16  saturating count of out-of-range pixels.

Behaviour:
- Reset values: FIFO empty, in_ready=1, mem_we=0, mem_addr=0, mem_data=0, busy=0, drop_count=0.
- Accept condition: a pixel is accepted on an edge where in_valid && in_ready.
- Out-of-range pixels: if in_x>=SCREEN_W or in_y>=SCREEN_H, the pixel is accepted but not stored, and drop_count increments, saturating at 16'hFFFF.
- Address: addr = in_y*SCREEN_W + in_x, computed at input. For 640 it is implemented as (y<<9)+(y<<7)+x. Result is 19 bits unsigned (max 307199, no overflow).
- FIFO storage: {addr, color} per entry; read/write pointers are log2(DEPTH)+1 bits wide.
  - full when pointers differ only in the MSB.
  - empty when pointers are equal.
  - No input-to-output bypass, so a push is never permitted while full, even if a pop occurs the same edge.
- Output stage: one register {mem_we, mem_addr, mem_data}.
  - Loads from the FIFO head on an edge where !empty && (!mem_we || mem_ready).
  - Otherwise mem_we clears on an edge where mem_ready is high.
  - mem_addr and mem_data must be held stable while mem_we && !mem_ready.
- Latency: a pixel accepted on edge k into an empty buffer drives mem_we=1 from edge k+1. Throughput is one write per cycle while mem_ready=1.
- Ordering: writes issue strictly in acceptance order.
- Simultaneous push and pop (not full): both occur; count is unchanged.
- flush: takes effect on the edge. Discards the FIFO and clears mem_we, including any write in flight. Any push requested on the same edge is ignored.
  - flush takes priority over push.
  - reset takes priority over flush.
- Reset mid-operation: all pending pixels are lost; outputs return to reset values immediately (asynchronous).
- busy = !empty || mem_we, combinational.

Optional Feature:
- Macro: PIXEL_DEDUP_EN.
- Defined: a last-issued register {valid, addr, color} is kept.
  - A FIFO head whose addr and color both equal the last-issued value is popped without loading the output stage (no write).
  - The register updates on each load.
  - Reset and flush invalidate it.
- Not defined: every in-range pixel produces exactly one write; no extra registers exist.

Decomposition:
- Package fb_pkg:
  - SCREEN_W, SCREEN_H, X_W=10, Y_W=9, ADDR_W=19.
  - typedef struct packed {logic [ADDR_W-1:0] addr; logic color;} fb_wr_t.
  - function fb_addr(x, y).
- Sub-module: pixel_fifo (synchronous, parameterised DEPTH, data type fb_wr_t), with push/pop/full/empty/flush ports.

Test Plan:
- Single pixel: x=5, y=2, color=1, mem_ready=1 → after one edge mem_we=1, mem_addr=1285, mem_data=1; mem_we=0 the next cycle; busy falls.
- Back-pressure: mem_ready=0, push 17 pixels with DEPTH=16 → first goes to the output stage, 16 fill the FIFO, in_ready=0. Release mem_ready → 17 writes in order, unchanged.
- Range drop: push (640,0), (0,480), (639,479) → drop_count=2, one write to addr 307199.
- Saturation: force 65537 out-of-range pixels → drop_count holds 16'hFFFF.
- Flush under load: FIFO holding 8 entries, mem_ready=0, flush for one cycle → mem_we=0, busy=0, in_ready=1. A subsequent pixel writes with latency 1.
- Dedup: with PIXEL_DEDUP_EN, push (3,3,1) three times then (3,3,0) → exactly 2 writes. Without the macro → 4 writes.
